readout_seq: RTL and testbench

Sequences readout of the 2x2 pixel array after exposure completes. It drives the active-low row selects NRE_R1/NRE_R2 and strobes the ADC for each row. It performs a done/timeout handshake with the converter and presents each row's two column samples on a valid-qualified output. It sits between the main camera FSM and the ADC, and replaces the fixed readout timing in that FSM with a parameterised, handshaked sequence.

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cycle_timer.sv | 25 ++
 rtl/readout_seq.sv | 128 ++++++++++++
 tb/tb_readout_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera readout path.
package cam_pkg;

  localparam int W_DEF       = 8;
  localparam int SETTLE_DEF  = 2;
  localparam int HOLD_DEF    = 1;
  localparam int TIMEOUT_DEF = 15;

  localparam logic ROW1 = 1'b0;
  localparam logic ROW2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONV,
    ST_WAIT,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } rd_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with zero flag; shared by the settle, hold and timeout intervals.
module cycle_timer #(
  parameter int TW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (load_i)
      cnt_q <= val_i;
    else if (cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/readout_seq.sv
// 2x2 pixel array readout sequencer: row select, ADC strobe, done/timeout
// handshake and valid-qualified row sample output.
module readout_seq
  import cam_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int HOLD    = HOLD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Adc_done,
  input  logic [2*W-1:0] Adc_data,
  output logic           NRE_R1,
  output logic           NRE_R2,
  output logic           ADC,
  output logic [2*W-1:0] Pix_data,
  output logic           Pix_row,
  output logic           Pix_valid,
  output logic           Busy,
  output logic           Done,
  output logic           Err
);

  localparam int TMAX = max3(SETTLE, HOLD, TIMEOUT);
  localparam int TW   = $clog2(TMAX + 1);

  rd_state_t      state_q, state_d;
  logic           row_q, abort_q, err_q;
  logic           pix_valid_q, pix_row_q;
  logic [2*W-1:0] pix_data_q;
  logic           tmr_load, tmr_zero;
  logic [TW-1:0]  tmr_val;
  logic           row_sel;

  cycle_timer #(.TW(TW)) u_timer (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Start) state_d = ST_SETTLE;
      ST_SETTLE: if (tmr_zero) state_d = ST_CONV;
      ST_CONV:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (Adc_done)      state_d = ST_HOLD;
        else if (tmr_zero) state_d = ST_GAP;
      end
      ST_HOLD:   if (tmr_zero) state_d = ST_GAP;
      ST_GAP:    state_d = (row_q == ROW1 && !abort_q) ? ST_SETTLE : ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // The timer is reloaded on every state entry, so each interval counts N-1 down to zero.
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_SETTLE: tmr_val = TW'(SETTLE - 1);
      ST_WAIT:   tmr_val = TW'(TIMEOUT - 1);
      ST_HOLD:   tmr_val = TW'(HOLD - 1);
      default:   tmr_val = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_q       <= ROW1;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_row_q   <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      pix_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            row_q   <= ROW1;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (Adc_done) begin
            pix_data_q  <= Adc_data;
            pix_row_q   <= row_q;
            pix_valid_q <= 1'b1;
          end else if (tmr_zero) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (row_q == ROW1 && !abort_q) row_q <= ROW2;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    row_sel   = (state_q == ST_SETTLE) || (state_q == ST_CONV) ||
                (state_q == ST_WAIT)   || (state_q == ST_HOLD);
    NRE_R1    = !(row_sel && row_q == ROW1);
    NRE_R2    = !(row_sel && row_q == ROW2);
    ADC       = (state_q == ST_CONV);
    Busy      = (state_q != ST_IDLE);
    Done      = (state_q == ST_DONE);
    Pix_valid = pix_valid_q;
    Pix_row   = pix_row_q;
    Pix_data  = pix_data_q;
    Err       = err_q;
  end

endmodule

// File: tb/tb_readout_seq.sv
// Directed bench for readout_seq: per-cycle waveform table checks plus a
// scoreboard of expected Pix_valid and Done events checked by a monitor.
module tb_readout_seq;

  logic        Clk = 1'b0;
  logic        Reset, Start, Adc_done;
  logic [15:0] Adc_data;
  logic        NRE_R1, NRE_R2, ADC, Pix_row, Pix_valid, Busy, Done, Err;
  logic [15:0] Pix_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  readout_seq #(.W(8), .SETTLE(2), .HOLD(1), .TIMEOUT(15)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Adc_done  (Adc_done),
    .Adc_data  (Adc_data),
    .NRE_R1    (NRE_R1),
    .NRE_R2    (NRE_R2),
    .ADC       (ADC),
    .Pix_data  (Pix_data),
    .Pix_row   (Pix_row),
    .Pix_valid (Pix_valid),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  typedef struct {
    logic [15:0] data;
    logic        row;
    int          at;
  } pix_t;

  // All cycle fields are relative to the cycle in which Start is first driven.
  typedef struct {
    logic [31:0] dmask;
    logic [15:0] d1, d2;
    bit          hold;
    int xs1, xs2, rst_rel, len;
    int r1f, r1l, r2f, r2l, a1, a2, p1, p2, done_at, busy_last, err_from;
  } vec_t;

  pix_t exp_pix[$];
  int   exp_done[$];
  pix_t mon_e;
  int   mon_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] dm, input logic [15:0] d1, input logic [15:0] d2,
                              input bit hold, input int xs1, input int xs2, input int rst_rel,
                              input int len, input int r1f, input int r1l, input int r2f,
                              input int r2l, input int a1, input int a2, input int p1,
                              input int p2, input int done_at, input int busy_last,
                              input int err_from);
    vec_t v;
    v.dmask = dm; v.d1 = d1; v.d2 = d2; v.hold = hold;
    v.xs1 = xs1; v.xs2 = xs2; v.rst_rel = rst_rel; v.len = len;
    v.r1f = r1f; v.r1l = r1l; v.r2f = r2f; v.r2l = r2l;
    v.a1 = a1; v.a2 = a2; v.p1 = p1; v.p2 = p2;
    v.done_at = done_at; v.busy_last = busy_last; v.err_from = err_from;
    return v;
  endfunction

  always @(negedge Clk) begin
    if (Pix_valid === 1'b1) begin
      if (exp_pix.size() == 0) begin
        checks++; failures++;
        $display("FAIL pix_unexpected: Pix_valid=1 row=%0d data=%0h at cycle %0d, expected none",
                 Pix_row, Pix_data, cyc);
      end else begin
        mon_e = exp_pix.pop_front();
        chk("pix_data", Pix_data, mon_e.data);
        chk("pix_row", Pix_row, mon_e.row);
        chk("pix_cycle", cyc, mon_e.at);
      end
    end
    if (Done === 1'b1) begin
      if (exp_done.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected: Done=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_d = exp_done.pop_front();
        chk("done_cycle", cyc, mon_d);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_nre_r1", NRE_R1, 1);
    chk("rst_nre_r2", NRE_R2, 1);
    chk("rst_adc", ADC, 0);
    chk("rst_pix_valid", Pix_valid, 0);
    chk("rst_pix_data", Pix_data, 0);
    chk("rst_pix_row", Pix_row, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Err, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int   t0;
    pix_t e;
    t0 = cyc;
    if (v.p1 >= 0) begin e.data = v.d1; e.row = 1'b0; e.at = t0 + v.p1; exp_pix.push_back(e); end
    if (v.p2 >= 0) begin e.data = v.d2; e.row = 1'b1; e.at = t0 + v.p2; exp_pix.push_back(e); end
    if (v.done_at >= 0) exp_done.push_back(t0 + v.done_at);
    for (int rel = 0; rel < v.len; rel++) begin
      Start    = (rel == 0) || v.hold || (rel == v.xs1) || (rel == v.xs2);
      Adc_done = v.dmask[rel];
      Adc_data = (rel <= v.r1l) ? v.d1 : v.d2;
      Reset    = (rel == v.rst_rel);
      chk("nre_r1", NRE_R1, !(v.r1f >= 0 && rel >= v.r1f && rel <= v.r1l));
      chk("nre_r2", NRE_R2, !(v.r2f >= 0 && rel >= v.r2f && rel <= v.r2l));
      chk("adc", ADC, (rel == v.a1) || (rel == v.a2));
      chk("busy", Busy, (rel >= 1) && (rel <= v.busy_last));
      if (rel >= 1) chk("err", Err, (v.err_from >= 0) && (rel >= v.err_from));
      @(posedge Clk); #1;
    end
    if (v.rst_rel >= 0) begin
      check_reset_vals();
      Reset = 1'b0;
    end
    Adc_done = 1'b0;
    Start    = v.hold;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Adc_done = 1'b0; Adc_data = '0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals();
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Nominal: done on first WAIT cycle of each row.
    run_vec(mk(32'h0410, 16'hA155, 16'h3C7E, 0, -1, -1, -1, 15, 1, 5, 7, 11, 3, 9, 5, 11, 13, 13, -1));
    chk("pix_data_hold", Pix_data, 16'h3C7E);
    // Stray Adc_done in HOLD/GAP, extra Start mid-sequence and in DONE.
    run_vec(mk(32'h1470, 16'h1234, 16'hABCD, 0, 5, 13, -1, 17, 1, 5, 7, 11, 3, 9, 5, 11, 13, 13, -1));
    // Row-1 done on the 5th WAIT cycle.
    run_vec(mk(32'h4100, 16'h5A0F, 16'hC3E1, 0, -1, -1, -1, 19, 1, 9, 11, 15, 3, 13, 9, 15, 17, 17, -1));
    // Converter never answers.
    run_vec(mk(32'h0000, 16'hBEEF, 16'hCAFE, 0, -1, -1, -1, 22, 1, 18, -1, -1, 3, -1, -1, -1, 20, 20, 19));
    // Done pulses only in SETTLE/CONV: still times out; Start clears prior Err.
    run_vec(mk(32'h000E, 16'hD00D, 16'hF00D, 0, -1, -1, -1, 22, 1, 18, -1, -1, 3, -1, -1, -1, 20, 20, 19));
    run_vec(mk(32'h0410, 16'h0F0F, 16'hF0F0, 0, -1, -1, -1, 15, 1, 5, 7, 11, 3, 9, 5, 11, 13, 13, -1));
    // Start held high: back-to-back sequences.
    run_vec(mk(32'h0410, 16'h1111, 16'h2222, 1, -1, -1, -1, 14, 1, 5, 7, 11, 3, 9, 5, 11, 13, 13, -1));
    run_vec(mk(32'h0410, 16'h3333, 16'h4444, 1, -1, -1, -1, 14, 1, 5, 7, 11, 3, 9, 5, 11, 13, 13, -1));
    run_vec(mk(32'h0410, 16'h5555, 16'h6666, 0, -1, -1, -1, 15, 1, 5, 7, 11, 3, 9, 5, 11, 13, 13, -1));
    // Reset while waiting on row 2, then a clean sequence.
    run_vec(mk(32'h0010, 16'h7777, 16'h8888, 0, -1, -1, 10, 11, 1, 5, 7, 10, 3, 9, 5, -1, -1, 10, -1));
    @(posedge Clk); #1;
    run_vec(mk(32'h0410, 16'h9A9A, 16'hBCBC, 0, -1, -1, -1, 15, 1, 5, 7, 11, 3, 9, 5, 11, 13, 13, -1));

    repeat (3) @(posedge Clk);
    #1;
    chk("pix_queue_empty", exp_pix.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
